vga_sig_gen: RTL and testbench

//  VGA timing generator and pixel fetch stage, downstream of the frame buffer's read-only port.

---
 rtl/vga_sig_gen.sv | 71 +++++++
 tb/tb_vga_sig_gen.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/vga_sig_gen.sv
// vga_sig_gen: 640x480@60Hz VGA timing generator fetching a 1-bit frame buffer
// drawn as 4x4 blocks, single clock with a CLK/PIX_DIV pixel enable.
module vga_sig_gen #(
  parameter int PIX_DIV = 4,
  parameter int H_VIS = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_VIS = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic [7:0] FG_RST = 8'hFF,
  parameter logic [7:0] BG_RST = 8'h00
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [15:0] CONFIG_COLOURS,
  output logic [14:0] VGA_ADDR,
  input  logic        VGA_DATA,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic [7:0]  VGA_COLOUR,
  output logic        FRAME_START
);
  localparam int DW = $clog2(PIX_DIV);
  localparam logic [DW-1:0] D_MAX = DW'(PIX_DIV - 1);
  localparam logic [9:0] H_MAX = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_B = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_E = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_B = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_E = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] HV = 10'(H_VIS);
  localparam logic [9:0] VV = 10'(V_VIS);
  logic [DW-1:0] div;
  logic [9:0] hcnt, vcnt;
  logic [7:0] fg, bg;
  logic ce, h_end, v_end, vis;
  always_comb begin
    ce = div == D_MAX;
    h_end = hcnt == H_MAX;
    v_end = vcnt == V_MAX;
    vis = (hcnt < HV) && (vcnt < VV);
  end
  assign VGA_ADDR = {vcnt[8:2], hcnt[9:2]};
  // Outputs are registered from the pre-advance counters, so all lag one pixel together
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      div <= '0;
      hcnt <= '0;
      vcnt <= '0;
      VGA_HS <= 1'b1;
      VGA_VS <= 1'b1;
      VGA_COLOUR <= 8'h00;
      FRAME_START <= 1'b0;
      fg <= FG_RST;
      bg <= BG_RST;
    end else begin
      div <= ce ? '0 : div + 1'b1;
      FRAME_START <= ce && h_end && v_end;
      if (ce) begin
        hcnt <= h_end ? '0 : hcnt + 10'd1;
        if (h_end) vcnt <= v_end ? '0 : vcnt + 10'd1;
        VGA_COLOUR <= vis ? (VGA_DATA ? fg : bg) : 8'h00;
        VGA_HS <= ~((hcnt >= HS_B) && (hcnt < HS_E));
        VGA_VS <= ~((vcnt >= VS_B) && (vcnt < VS_E));
        if (h_end && v_end) {fg, bg} <= CONFIG_COLOURS;
      end
    end
endmodule

// File: tb/tb_vga_sig_gen.sv
// tb_vga_sig_gen: directed checks of vga_sig_gen on a shrunken 24x17-pixel raster
// (16x12 visible, HS low at pixels 18..20, VS low at lines 13..14, PIX_DIV=4).
module tb_vga_sig_gen;
  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  logic [15:0] CONFIG_COLOURS = 16'hFF00;
  logic [14:0] VGA_ADDR;
  logic VGA_DATA = 1'b0;
  logic VGA_HS, VGA_VS, FRAME_START;
  logic [7:0] VGA_COLOUR;
  logic mode = 1'b0;
  int cyc, n_cmp = 0, n_bad = 0;
  int hs_f1, hs_r1, hs_f2, vs_f1, vs_r1, fs_r1, fs_f1, fs_r2, nz_cnt, nz_first, nz_last;
  logic ph, pv, pf;

  vga_sig_gen #(.PIX_DIV(4), .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
                .V_VIS(12), .V_FP(1), .V_SYNC(2), .V_BP(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .CONFIG_COLOURS(CONFIG_COLOURS), .VGA_ADDR(VGA_ADDR),
    .VGA_DATA(VGA_DATA), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_COLOUR(VGA_COLOUR),
    .FRAME_START(FRAME_START));

  always #5 CLK = ~CLK;

  // frame buffer: mode 0 holds a single set pixel at 15'h0102, mode 1 is all ones
  always @(posedge CLK) VGA_DATA <= mode ? 1'b1 : (VGA_ADDR == 15'h0102);

  always @(posedge CLK or negedge RESETN)
    if (!RESETN) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge CLK)
    if (!RESETN) begin
      {hs_f1, hs_r1, hs_f2, vs_f1, vs_r1, fs_r1, fs_f1, fs_r2} <= {8{-32'sd1}};
      {nz_cnt, nz_first, nz_last} <= {0, -1, -1};
      {ph, pv, pf} <= 3'b110;
    end else begin
      ph <= VGA_HS;
      pv <= VGA_VS;
      pf <= FRAME_START;
      if (ph && !VGA_HS) begin
        if (hs_f1 < 0) hs_f1 <= cyc;
        else if (hs_f2 < 0) hs_f2 <= cyc;
      end
      if (!ph && VGA_HS && hs_r1 < 0) hs_r1 <= cyc;
      if (pv && !VGA_VS && vs_f1 < 0) vs_f1 <= cyc;
      if (!pv && VGA_VS && vs_r1 < 0) vs_r1 <= cyc;
      if (!pf && FRAME_START) begin
        if (fs_r1 < 0) fs_r1 <= cyc;
        else if (fs_r2 < 0) fs_r2 <= cyc;
      end
      if (pf && !FRAME_START && fs_f1 < 0) fs_f1 <= cyc;
      if (VGA_COLOUR != 8'h00 && cyc < 1632) begin
        nz_cnt <= nz_cnt + 1;
        if (nz_first < 0) nz_first <= cyc;
        nz_last <= cyc;
      end
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // advance until cyc edges have elapsed since reset release, sampling 1 time unit after the edge
  task automatic wait_cyc(input int n);
    for (int i = 0; i < 100000; i++) begin
      if (cyc >= n) return;
      @(posedge CLK);
      #1;
    end
    check("wait_bound", cyc, n);
  endtask

  task automatic restart();
    @(negedge CLK) RESETN = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RESETN = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_hs", VGA_HS, 1);
    check("rst_vs", VGA_VS, 1);
    check("rst_col", VGA_COLOUR, 0);
    check("rst_fs", FRAME_START, 0);
    check("rst_addr", VGA_ADDR, 0);
    @(negedge CLK) RESETN = 1'b1;
    wait_cyc(15);  check("addr_pre_ce4", VGA_ADDR, 15'h0000);
    wait_cyc(16);  check("addr_ce4", VGA_ADDR, 15'h0001);
    wait_cyc(415); check("addr_7_4", VGA_ADDR, 15'h0101);
    wait_cyc(416); check("addr_8_4", VGA_ADDR, 15'h0102);
    wait_cyc(419); check("col_before_px", VGA_COLOUR, 8'h00);
    wait_cyc(420); check("col_px", VGA_COLOUR, 8'hFF);
    wait_cyc(1640);
    check("hs_first_fall", hs_f1, 76);
    check("hs_low_len", hs_r1 - hs_f1, 12);
    check("line_period", hs_f2 - hs_f1, 96);
    check("vs_first_fall", vs_f1, 1252);
    check("vs_low_len", vs_r1 - vs_f1, 192);
    check("fs_rise", fs_r1, 1632);
    check("fs_width", fs_f1 - fs_r1, 1);
    check("px_clks", nz_cnt, 64);
    check("px_first", nz_first, 420);
    check("px_last", nz_last, 723);

    mode = 1'b1;
    CONFIG_COLOURS = 16'hE01C;
    restart();
    wait_cyc(3);    check("ones_col_pre", VGA_COLOUR, 8'h00);
    wait_cyc(4);    check("ones_col_f1", VGA_COLOUR, 8'hFF);
    wait_cyc(1632); check("ones_fs", FRAME_START, 1);
    check("ones_col_wrap", VGA_COLOUR, 8'h00);
    wait_cyc(1636); check("ones_col_f2", VGA_COLOUR, 8'hE0);
    wait_cyc(1699); check("ones_col_lastvis", VGA_COLOUR, 8'hE0);
    wait_cyc(1700); check("ones_col_porch", VGA_COLOUR, 8'h00);
    wait_cyc(2000); CONFIG_COLOURS = 16'h03C0;
    wait_cyc(2404); check("ones_col_midchg", VGA_COLOUR, 8'hE0);
    wait_cyc(3267); check("ones_col_blank", VGA_COLOUR, 8'h00);
    wait_cyc(3268); check("ones_col_f3", VGA_COLOUR, 8'h03);
    check("fs_period", fs_r2 - fs_r1, 1632);

    restart();
    wait_cyc(42); check("mid_col_vis", VGA_COLOUR, 8'hFF);
    #2 RESETN = 1'b0;
    #1 check("async_col", VGA_COLOUR, 8'h00);
    check("async_addr", VGA_ADDR, 15'h0000);
    @(negedge CLK) RESETN = 1'b1;
    wait_cyc(80); check("mid_hs_low", VGA_HS, 0);
    #2 RESETN = 1'b0;
    #1 check("async_hs", VGA_HS, 1);
    @(negedge CLK) RESETN = 1'b1;
    wait_cyc(1260); check("mid_vs_low", VGA_VS, 0);
    check("hs_fall_after_rst", hs_f1, 76);
    #2 RESETN = 1'b0;
    #1 check("async_vs", VGA_VS, 1);
    @(negedge CLK) RESETN = 1'b1;
    wait_cyc(3); check("restart_pre", VGA_COLOUR, 8'h00);
    wait_cyc(4); check("restart_px0", VGA_COLOUR, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
